// File: rtl/ibex_rf_wb_buffer.sv
// ibex_rf_wb_buffer: in-order write-back FIFO to the RF write port with read forwarding; RF_WB_COALESCE_EN merges writes to a pending register
module ibex_rf_wb_buffer #(
  parameter int DataWidth = 32,
  parameter int Depth     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [4:0]           waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 wr_stall_o,
  input  logic                 rf_busy_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  output logic                 fwd_a_valid_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  input  logic [4:0]           raddr_b_i,
  output logic                 fwd_b_valid_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 empty_o
);
  localparam int PW = $clog2(Depth);
  logic [4:0]           r_addr [Depth];
  logic [DataWidth-1:0] r_data [Depth];
  logic [PW-1:0]        r_rd_ptr, r_wr_ptr;
  logic [PW:0]          r_count;
  logic                 w_wr, w_full, w_pop, w_acc, w_enq, w_coal;
  assign w_wr       = we_i & (waddr_i != 5'd0);
  assign w_full     = r_count == (PW+1)'(Depth);
  assign w_pop      = (r_count != '0) & ~rf_busy_i & ~rst_i;
  assign w_acc      = w_wr & (w_coal | ~w_full | w_pop);
  assign w_enq      = w_acc & ~w_coal & ~rst_i;
  assign wr_stall_o = w_wr & w_full & rf_busy_i & ~w_coal;
  assign rf_we_o    = w_pop;
  assign rf_waddr_o = r_addr[r_rd_ptr];
  assign rf_wdata_o = r_data[r_rd_ptr];
  assign empty_o    = r_count == '0;
`ifdef RF_WB_COALESCE_EN
  logic          w_cm;
  logic [PW-1:0] w_cidx;
  // youngest pending entry with the incoming address, excluding a head leaving this cycle
  always_comb begin
    w_cm   = 1'b0;
    w_cidx = '0;
    for (int k = 0; k < Depth; k++)
      if ((PW+1)'(k) < r_count && !(k == 0 && w_pop) && r_addr[r_rd_ptr + PW'(k)] == waddr_i) begin
        w_cm   = 1'b1;
        w_cidx = r_rd_ptr + PW'(k);
      end
  end
  assign w_coal = w_wr & w_cm;
`else
  assign w_coal = 1'b0;
`endif
  // pointer and occupancy state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      r_count <= (w_enq & ~w_pop) ? r_count + (PW+1)'(1) :
                 (~w_enq & w_pop) ? r_count - (PW+1)'(1) : r_count;
    end
  end
  // entry storage, left uncleared by reset
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_addr[r_wr_ptr] <= waddr_i;
      r_data[r_wr_ptr] <= wdata_i;
    end
`ifdef RF_WB_COALESCE_EN
    if (w_coal & ~rst_i) r_data[w_cidx] <= wdata_i;
`endif
  end
  // forwarding: incoming accepted write beats the youngest matching entry
  always_comb begin
    fwd_a_valid_o = 1'b0;
    fwd_a_data_o  = '0;
    fwd_b_valid_o = 1'b0;
    fwd_b_data_o  = '0;
    for (int k = 0; k < Depth; k++)
      if ((PW+1)'(k) < r_count) begin
        if (raddr_a_i != 5'd0 && r_addr[r_rd_ptr + PW'(k)] == raddr_a_i) begin
          fwd_a_valid_o = 1'b1;
          fwd_a_data_o  = r_data[r_rd_ptr + PW'(k)];
        end
        if (raddr_b_i != 5'd0 && r_addr[r_rd_ptr + PW'(k)] == raddr_b_i) begin
          fwd_b_valid_o = 1'b1;
          fwd_b_data_o  = r_data[r_rd_ptr + PW'(k)];
        end
      end
    if (w_acc && waddr_i == raddr_a_i) begin
      fwd_a_valid_o = 1'b1;
      fwd_a_data_o  = wdata_i;
    end
    if (w_acc && waddr_i == raddr_b_i) begin
      fwd_b_valid_o = 1'b1;
      fwd_b_data_o  = wdata_i;
    end
  end
endmodule
